// File: rtl/conv_pkg.sv
// Shared defaults and helpers for the convolution window sequencer.
package conv_pkg;

  localparam int unsigned ADDR_W_DEF  = 4;
  localparam int unsigned PARAM_W_DEF = 4;

  // A zero stride or filter size would stall the window; treat it as 1.
  function automatic int unsigned clamp_one(input int unsigned v);
    return (v == 0) ? 1 : v;
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Counter with clear/load/increment that wraps to zero after reaching max_i.
module wrap_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             inc_i,
  input  logic [Width-1:0] max_i,
  output logic [Width-1:0] count_o,
  output logic             tc_o
);

  logic [Width-1:0] count_q, count_d;

  assign tc_o    = (count_q == max_i);
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (inc_i) begin
      count_d = tc_o ? '0 : count_q + Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/conv_window_sequencer.sv
// Tap/window/filter sequencing and scratchpad addressing for the convolution datapath.
module conv_window_sequencer
  import conv_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned PARAM_W     = PARAM_W_DEF,
  parameter int unsigned NUM_FILTERS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PARAM_W-1:0]  stride_in,
  input  logic [PARAM_W-1:0]  filter_size_in,
  input  logic                ld_stride,
  input  logic                ld_filterSize,
  input  logic                put_data,
  input  logic                put_filter,
  input  logic                next_filter,
  input  logic                next_row,
  input  logic [ADDR_W:0]     row_len,
  input  logic [ADDR_W:0]     data_level,
  input  logic [ADDR_W:0]     filter_level,
  output logic [ADDR_W-1:0]   data_raddr,
  output logic [ADDR_W-1:0]   filter_raddr,
  output logic                av_data,
  output logic                av_filter,
  output logic                co_filter,
  output logic                end_of_row,
  output logic                end_of_filter,
  output logic                row_done
);

  localparam int unsigned FiltW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
  // Wide enough that win_base + fsize never wraps.
  localparam int unsigned EorW  = (ADDR_W + 2 > PARAM_W + 1) ? ADDR_W + 2 : PARAM_W + 1;

  logic [PARAM_W-1:0] stride_q, stride_d, fsize_q, fsize_d;
  logic [ADDR_W-1:0]  win_base_q, win_base_d, filt_base_q, filt_base_d;
  logic               co_filter_q, co_filter_d, row_done_q, row_done_d;
  logic [PARAM_W-1:0] tap;
  logic [FiltW-1:0]   filt_idx;
  logic               tap_tc, filt_tc;
  logic               ld_any, take_row, take_filter, take_accept;

  assign ld_any      = ld_stride | ld_filterSize;
  assign take_row    = !ld_any && next_row;
  assign take_filter = !ld_any && !next_row && next_filter;
  assign take_accept = !ld_any && !next_row && !next_filter && put_data && put_filter;

  wrap_counter #(
    .Width (PARAM_W)
  ) u_tap (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (ld_any | next_row | next_filter),
    .load_i     (1'b0),
    .load_val_i ('0),
    .inc_i      (take_accept),
    .max_i      (fsize_q - PARAM_W'(1)),
    .count_o    (tap),
    .tc_o       (tap_tc)
  );

  wrap_counter #(
    .Width (FiltW)
  ) u_filt_idx (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (take_row),
    .load_i     (1'b0),
    .load_val_i ('0),
    .inc_i      (take_filter),
    .max_i      (FiltW'(NUM_FILTERS - 1)),
    .count_o    (filt_idx),
    .tc_o       (filt_tc)
  );

  always_comb begin
    stride_d    = stride_q;
    fsize_d     = fsize_q;
    win_base_d  = win_base_q;
    filt_base_d = filt_base_q;
    if (ld_stride)     stride_d = PARAM_W'(clamp_one(32'(stride_in)));
    if (ld_filterSize) fsize_d  = PARAM_W'(clamp_one(32'(filter_size_in)));
    if (ld_any) begin
      win_base_d = '0;
    end else if (next_row) begin
      win_base_d  = '0;
      filt_base_d = '0;
    end else if (next_filter) begin
      win_base_d  = '0;
      filt_base_d = filt_base_q + ADDR_W'(fsize_q);
    end else if (take_accept && tap_tc) begin
      win_base_d = win_base_q + ADDR_W'(stride_q);
    end
    co_filter_d = take_accept && tap_tc;
    row_done_d  = take_row;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stride_q    <= PARAM_W'(1);
      fsize_q     <= PARAM_W'(1);
      win_base_q  <= '0;
      filt_base_q <= '0;
      co_filter_q <= 1'b0;
      row_done_q  <= 1'b0;
    end else begin
      stride_q    <= stride_d;
      fsize_q     <= fsize_d;
      win_base_q  <= win_base_d;
      filt_base_q <= filt_base_d;
      co_filter_q <= co_filter_d;
      row_done_q  <= row_done_d;
    end
  end

  assign data_raddr    = win_base_q + ADDR_W'(tap);
  assign filter_raddr  = filt_base_q + ADDR_W'(tap);
  assign end_of_row    = (EorW'(win_base_q) + EorW'(fsize_q)) > EorW'(row_len);
  assign av_data       = ({1'b0, data_raddr} < data_level) && !end_of_row;
  assign av_filter     = {1'b0, filter_raddr} < filter_level;
  assign end_of_filter = filt_tc;
  assign co_filter     = co_filter_q;
  assign row_done      = row_done_q;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Directed and randomized bench for conv_window_sequencer against an arithmetic window model.
module tb_conv_window_sequencer;

  localparam int AW = 4;
  localparam int PW = 4;
  localparam int NF = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] stride_in, filter_size_in;
  logic          ld_stride, ld_filterSize, put_data, put_filter, next_filter, next_row;
  logic [AW:0]   row_len, data_level, filter_level;
  logic [AW-1:0] data_raddr, filter_raddr;
  logic          av_data, av_filter, co_filter, end_of_row, end_of_filter, row_done;

  always #5 clk = ~clk;

  conv_window_sequencer #(
    .ADDR_W      (AW),
    .PARAM_W     (PW),
    .NUM_FILTERS (NF)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stride_in      (stride_in),
    .filter_size_in (filter_size_in),
    .ld_stride      (ld_stride),
    .ld_filterSize  (ld_filterSize),
    .put_data       (put_data),
    .put_filter     (put_filter),
    .next_filter    (next_filter),
    .next_row       (next_row),
    .row_len        (row_len),
    .data_level     (data_level),
    .filter_level   (filter_level),
    .data_raddr     (data_raddr),
    .filter_raddr   (filter_raddr),
    .av_data        (av_data),
    .av_filter      (av_filter),
    .co_filter      (co_filter),
    .end_of_row     (end_of_row),
    .end_of_filter  (end_of_filter),
    .row_done       (row_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: taps consumed in the current window, windows completed, filter count.
  int m_stride, m_fsize, m_acc, m_win, m_fbase, m_filt;
  bit exp_co, exp_rd;

  function automatic int m_wbase();
    return (m_win * m_stride) % DEPTH;
  endfunction
  function automatic int m_daddr();
    return (m_wbase() + m_acc) % DEPTH;
  endfunction
  function automatic int m_faddr();
    return (m_fbase + m_acc) % DEPTH;
  endfunction
  function automatic bit m_eor();
    return (m_wbase() + m_fsize) > int'(row_len);
  endfunction
  function automatic bit m_av_data();
    return (m_daddr() < int'(data_level)) && !m_eor();
  endfunction
  function automatic bit m_av_filter();
    return m_faddr() < int'(filter_level);
  endfunction

  function automatic void model_update();
    exp_co = 1'b0;
    exp_rd = 1'b0;
    if (rst) begin
      m_stride = 1; m_fsize = 1; m_acc = 0; m_win = 0; m_fbase = 0; m_filt = 0;
    end else if (ld_stride || ld_filterSize) begin
      if (ld_stride)     m_stride = (stride_in == 0) ? 1 : int'(stride_in);
      if (ld_filterSize) m_fsize  = (filter_size_in == 0) ? 1 : int'(filter_size_in);
      m_acc = 0; m_win = 0;
    end else if (next_row) begin
      m_acc = 0; m_win = 0; m_fbase = 0; m_filt = 0;
      exp_rd = 1'b1;
    end else if (next_filter) begin
      m_acc = 0; m_win = 0;
      m_fbase = (m_fbase + m_fsize) % DEPTH;
      m_filt = (m_filt + 1) % NF;
    end else if (put_data && put_filter) begin
      m_acc++;
      if (m_acc == m_fsize) begin
        m_acc = 0;
        m_win++;
        exp_co = 1'b1;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("co_filter", co_filter, exp_co);
    chk("row_done", row_done, exp_rd);
    chk("data_raddr", data_raddr, m_daddr());
    chk("filter_raddr", filter_raddr, m_faddr());
    chk("end_of_row", end_of_row, m_eor());
    chk("end_of_filter", end_of_filter, m_filt == NF - 1);
    chk("av_data", av_data, m_av_data());
    chk("av_filter", av_filter, m_av_filter());
  endtask

  // Inputs are stable from here until the next edge; accepts must only happen when available.
  task automatic tick();
    #1;
    if (!rst && put_data && put_filter &&
        !(ld_stride || ld_filterSize || next_row || next_filter))
      chk("protocol_avail", av_data && av_filter, 1);
    @(posedge clk);
    model_update();
    #1;
    check_outputs();
  endtask

  task automatic idle();
    ld_stride = 0; ld_filterSize = 0; put_data = 0; put_filter = 0;
    next_filter = 0; next_row = 0;
  endtask

  int co_cnt;
  int r;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1; stride_in = 0; filter_size_in = 0;
    row_len = 8; data_level = 16; filter_level = 16;
    m_stride = 0; m_fsize = 0; m_acc = 0; m_win = 0; m_fbase = 0; m_filt = 0;
    tick();
    rst = 0;
    tick();

    // Stride 1, filter size 3 over an 8-entry row.
    stride_in = 1; filter_size_in = 3; ld_stride = 1; ld_filterSize = 1;
    tick();
    idle();
    co_cnt = 0;
    put_data = 1; put_filter = 1;
    for (int i = 0; i < 18; i++) begin
      tick();
      if (co_filter) co_cnt++;
      if (i == 17) chk("eor_with_6th_window", end_of_row, 1);
    end
    idle();
    chk("windows_stride1", co_cnt, 6);

    // Stride 2: windows at 0, 2, 4 only.
    stride_in = 2; ld_stride = 1;
    tick();
    idle();
    co_cnt = 0;
    for (int i = 0; i < 40 && !m_eor(); i++) begin
      put_data = 1; put_filter = 1;
      tick();
      if (co_filter) co_cnt++;
    end
    idle();
    chk("windows_stride2", co_cnt, 3);
    chk("eor_stride2", end_of_row, 1);

    // Filter stepping, then combined next_row/next_filter.
    next_filter = 1;
    tick();
    idle();
    chk("filter_base_3", filter_raddr, 3);
    chk("last_filter", end_of_filter, 1);
    put_data = 1; put_filter = 1;
    repeat (4) tick();
    idle();
    next_row = 1; next_filter = 1;
    tick();
    idle();
    chk("row_done_pulse", row_done, 1);
    tick();
    chk("row_done_single", row_done, 0);
    chk("filter_raddr_after_row", filter_raddr, 0);

    // Availability gating.
    stride_in = 1; ld_stride = 1;
    tick();
    idle();
    data_level = 2;
    put_data = 1; put_filter = 1;
    repeat (2) tick();
    idle();
    tick();
    chk("av_data_starved", av_data, 0);
    data_level = 3;
    #1;
    chk("av_data_refilled", av_data, 1);
    put_data = 1; put_filter = 1;
    tick();
    idle();
    filter_level = 0;
    #1;
    chk("av_filter_empty", av_filter, 0);
    filter_level = 1;
    #1;
    chk("av_filter_one", av_filter, 1);
    data_level = 16; filter_level = 16;

    // Zero parameters clamp to 1: every accept completes a window.
    stride_in = 0; filter_size_in = 0; ld_stride = 1; ld_filterSize = 1;
    tick();
    idle();
    co_cnt = 0;
    put_data = 1; put_filter = 1;
    repeat (4) begin
      tick();
      if (co_filter) co_cnt++;
    end
    idle();
    chk("co_every_accept", co_cnt, 4);

    // Reset in the middle of a window.
    stride_in = 1; filter_size_in = 3; ld_stride = 1; ld_filterSize = 1;
    tick();
    idle();
    put_data = 1; put_filter = 1;
    tick();
    idle();
    chk("mid_window_tap1", data_raddr, 1);
    rst = 1;
    tick();
    rst = 0;
    chk("reset_data_raddr", data_raddr, 0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      idle();
      r = int'($urandom_range(0, 99));
      if ($urandom_range(0, 15) == 0) row_len = 5'($urandom_range(1, 16));
      data_level   = 5'($urandom_range(0, 16));
      filter_level = 5'($urandom_range(4, 16));
      if (r < 2) begin
        rst = 1;
      end else if (r < 7) begin
        stride_in = 4'($urandom_range(0, 3));
        filter_size_in = 4'($urandom_range(0, 5));
        ld_stride = 1'($urandom_range(0, 1));
        ld_filterSize = !ld_stride || ($urandom_range(0, 1) == 1);
      end else if (r < 11) begin
        next_filter = 1;
      end else if (r < 14) begin
        next_row = 1;
        next_filter = 1'($urandom_range(0, 1));
      end else if (r < 85) begin
        if (m_av_data() && m_av_filter()) begin
          put_data = 1; put_filter = 1;
        end else begin
          put_data = 1'($urandom_range(0, 1));
        end
      end
      tick();
      rst = 0;
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
